// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit register value to byte/halfword/word and writes it out one
// byte per accepted memory beat, in big- or little-endian order.
module store_narrow_unit #(
  parameter int ENDIAN_BIG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] store_data,
  input  logic [1:0]  store_size,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte transfers at a rising edge where mem_we=1 and mem_ready=1;
  // while mem_ready=0 the address, data and mem_we hold unchanged.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  k_q, k_d;

  logic [1:0]  last_k;
  logic [1:0]  byte_sel;
  logic [7:0]  cur_byte;
  logic        misaligned;

  assign misaligned = (store_size == 2'b11) ||
                      (store_size == 2'b01 && base_addr[0]) ||
                      (store_size == 2'b10 && base_addr[1:0] != 2'b00);

  always_comb begin
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Selecting within [0, last_k] is what truncates the unused upper bytes.
  assign byte_sel = (ENDIAN_BIG != 0) ? (last_k - k_q) : k_q;

  always_comb begin
    case (byte_sel)
      2'd0:    cur_byte = data_q[7:0];
      2'd1:    cur_byte = data_q[15:8];
      2'd2:    cur_byte = data_q[23:16];
      default: cur_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    size_d  = size_q;
    addr_d  = addr_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = store_data;
          size_d  = store_size;
          addr_d  = base_addr;
          k_d     = 2'd0;
          state_d = misaligned ? S_ERR : S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (k_q == last_k) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= 32'd0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    misalign_err = (state_q == S_ERR);
    mem_we       = (state_q == S_WRITE);
    mem_addr     = 32'd0;
    mem_wdata    = 8'd0;
    if (state_q == S_WRITE) begin
      mem_addr  = addr_q + {30'd0, k_q};
      mem_wdata = cur_byte;
    end
  end

  assign dbg_state = state_q;

endmodule
